// File: rtl/exec_writeback_stage_pkg.sv
// Shared definitions for the execute/writeback stage.
//   - Opcode constants (final opcode after condition evaluation).
//   - Memory-access FSM state encoding.
//   - NZCV bit indices within the 4-bit flag vector {N,Z,C,V}.
//   - Small opcode-classification helpers used by the stage.
package exec_writeback_stage_pkg;

    // Opcodes 1..10 are further ALU operations; they behave exactly like OP_ADD here.
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_CMP = 4'd11;
    localparam logic [3:0] OP_ADR = 4'd12;
    localparam logic [3:0] OP_LDR = 4'd13;
    localparam logic [3:0] OP_STR = 4'd14;
    localparam logic [3:0] OP_NOP = 4'd15;

    localparam int unsigned NZCV_N = 32'd3;
    localparam int unsigned NZCV_Z = 32'd2;
    localparam int unsigned NZCV_C = 32'd1;
    localparam int unsigned NZCV_V = 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MEM   = 2'd1,
        ST_ABORT = 2'd2
    } wb_state_t;

    // ALU ops and ADR write their result; CMP only sets flags.
    function automatic logic writes_reg(input logic [3:0] op);
        return (op <= OP_ADR) && (op != OP_CMP);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

    // CMP always updates flags; other ALU/ADR ops only when S is set.
    function automatic logic sets_flags(input logic [3:0] op, input logic s);
        return (op <= OP_ADR) && (s || (op == OP_CMP));
    endfunction

endpackage

// File: rtl/exec_writeback_stage_mem_access_fsm.sv
// Memory-access controller for LDR/STR: IDLE/MEM/ABORT FSM, timeout counter
// and the req/ack handshake.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, start_we          launch a transaction (1 = store) from IDLE
//   start_addr, start_wdata  address / store data captured on start
//   mem_ack                  completion pulse (ignored outside MEM)
//   state                    current FSM state
//   mem_req/mem_we/mem_addr/mem_wdata  registered request, stable until ack
//   mem_err                  one-cycle pulse while in ABORT
//   done                     combinational: ack accepted this cycle
module mem_access_fsm
    import exec_writeback_stage_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              start_we,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [DATA_W-1:0] start_wdata,
    input  logic              mem_ack,
    output wb_state_t         state,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_err,
    output logic              done
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    wb_state_t         state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              req_r, req_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic              err_r, err_s;
    logic              done_s;

    // Next-state, counter and request-register logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        req_s   = req_r;
        we_s    = we_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        err_s   = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_MEM;
                    cnt_s   = '0;
                    req_s   = 1'b1;
                    we_s    = start_we;
                    addr_s  = start_addr;
                    wdata_s = start_wdata;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MEM: begin
                // Ack is checked first so an ack on the final cycle still succeeds.
                if (mem_ack) begin
                    done_s  = 1'b1;
                    req_s   = 1'b0;
                    state_s = ST_IDLE;
                end else if ((cnt_r + CNT_W'(1)) == CNT_W'(MEM_TIMEOUT)) begin
                    cnt_s   = cnt_r + CNT_W'(1);
                    req_s   = 1'b0;
                    err_s   = 1'b1;
                    state_s = ST_ABORT;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_ABORT: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                req_s   = 1'b0;
            end
        endcase
    end

    // State and request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            req_r   <= req_s;
            we_r    <= we_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            err_r   <= err_s;
        end
    end

    assign state     = state_r;
    assign mem_req   = req_r;
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_err   = err_r;
    assign done      = done_s;

endmodule

// File: rtl/exec_writeback_stage.sv
// Execute/writeback stage: captures the final opcode, ALU result and flags,
// then writes the register file, runs an LDR/STR through mem_access_fsm, or
// retires a NOP. Owns the architectural NZCV register.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready                 upstream handshake (ready only in IDLE)
//   in_opcode, in_s, in_result, in_nzcv, in_dst, in_addr, in_stdata
//                                     instruction payload
//   nzcv                              architectural flags {N,Z,C,V}
//   rf_we/rf_waddr/rf_wdata           register-file write port (pulse)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata  memory handshake
//   mem_err                           timeout abort pulse
//   retire                            one pulse per completed instruction
module exec_writeback_stage
    import exec_writeback_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int REG_AW      = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic              in_s,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_nzcv,
    input  logic [REG_AW-1:0] in_dst,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_stdata,
    output logic [3:0]        nzcv,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err,
    output logic              retire
);

    wb_state_t         state_s;
    logic              accept_s;
    logic              mem_start_s;
    logic              mem_done_s;
    logic [3:0]        nzcv_r;
    logic              rf_we_r;
    logic [REG_AW-1:0] rf_waddr_r;
    logic [DATA_W-1:0] rf_wdata_r;
    logic              retire_r;
    logic [REG_AW-1:0] ld_dst_r;

    assign in_ready    = (state_s == ST_IDLE);
    assign accept_s    = in_valid && in_ready;
    assign mem_start_s = accept_s && is_mem_op(in_opcode);

    mem_access_fsm #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem (
        .clk         (clk),
        .rst         (rst),
        .start       (mem_start_s),
        .start_we    (in_opcode == OP_STR),
        .start_addr  (in_addr),
        .start_wdata (in_stdata),
        .mem_ack     (mem_ack),
        .state       (state_s),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_err     (mem_err),
        .done        (mem_done_s)
    );

    // Flag register, writeback mux and retire pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            nzcv_r     <= 4'b0000;
            rf_we_r    <= 1'b0;
            rf_waddr_r <= '0;
            rf_wdata_r <= '0;
            retire_r   <= 1'b0;
            ld_dst_r   <= '0;
        end else begin
            rf_we_r  <= 1'b0;
            retire_r <= (accept_s && !is_mem_op(in_opcode)) || mem_done_s;
            if (accept_s && writes_reg(in_opcode)) begin
                rf_we_r    <= 1'b1;
                rf_waddr_r <= in_dst;
                rf_wdata_r <= in_result;
            end else if (mem_done_s && !mem_we) begin
                // Load completion; no accept can coincide since in_ready is low in MEM.
                rf_we_r    <= 1'b1;
                rf_waddr_r <= ld_dst_r;
                rf_wdata_r <= mem_rdata;
            end
            if (mem_start_s) begin
                ld_dst_r <= in_dst;
            end
            if (accept_s && sets_flags(in_opcode, in_s)) begin
                nzcv_r <= {in_nzcv[NZCV_N], in_nzcv[NZCV_Z], in_nzcv[NZCV_C], in_nzcv[NZCV_V]};
            end
        end
    end

    assign nzcv     = nzcv_r;
    assign rf_we    = rf_we_r;
    assign rf_waddr = rf_waddr_r;
    assign rf_wdata = rf_wdata_r;
    assign retire   = retire_r;

endmodule

// File: tb/tb_exec_writeback_stage.sv
module tb_exec_writeback_stage;
    import exec_writeback_stage_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int REG_AW = 4;
    localparam int TO     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_opcode;
    logic              in_s;
    logic [DATA_W-1:0] in_result;
    logic [3:0]        in_nzcv;
    logic [REG_AW-1:0] in_dst;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_stdata;
    logic [3:0]        nzcv;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;
    logic              retire;

    always #5 clk = ~clk;

    exec_writeback_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .MEM_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_s(in_s), .in_result(in_result), .in_nzcv(in_nzcv),
        .in_dst(in_dst), .in_addr(in_addr), .in_stdata(in_stdata), .nzcv(nzcv),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .retire(retire)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: instruction-level view with an outstanding-access record.
    logic              m_busy, m_abort, m_pend_load;
    int                m_waited;
    logic [REG_AW-1:0] m_pend_dst;
    logic [3:0]        m_nzcv;
    logic              m_rf_we, m_req, m_we, m_err, m_retire;
    logic [REG_AW-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata, m_mwdata;
    logic [ADDR_W-1:0] m_addr;

    // Predict the post-edge outputs from the inputs currently driven.
    task automatic model_step();
        int op;
        op       = int'(in_opcode);
        m_rf_we  = 1'b0;
        m_retire = 1'b0;
        m_err    = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_abort = 1'b0; m_pend_load = 1'b0; m_waited = 0; m_pend_dst = '0;
            m_nzcv = 4'b0000; m_req = 1'b0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
            m_addr = '0; m_mwdata = '0;
        end else if (m_abort) begin
            m_abort = 1'b0;
        end else if (m_busy) begin
            if (mem_ack) begin
                m_busy = 1'b0; m_req = 1'b0; m_retire = 1'b1;
                if (m_pend_load) begin
                    m_rf_we = 1'b1; m_waddr = m_pend_dst; m_wdata = mem_rdata;
                end
            end else begin
                m_waited++;
                if (m_waited == TO) begin
                    m_busy = 1'b0; m_abort = 1'b1; m_req = 1'b0; m_err = 1'b1;
                end
            end
        end else if (in_valid) begin
            if (op == 13 || op == 14) begin
                m_busy = 1'b1; m_waited = 0; m_req = 1'b1; m_we = (op == 14);
                m_pend_load = (op == 13); m_pend_dst = in_dst;
                m_addr = in_addr; m_mwdata = in_stdata;
            end else begin
                m_retire = 1'b1;
                if (op <= 12 && op != 11) begin
                    m_rf_we = 1'b1; m_waddr = in_dst; m_wdata = in_result;
                end
                if (op <= 12 && (in_s || op == 11)) m_nzcv = in_nzcv;
            end
        end
    endtask

    task automatic compare_all();
        check_val("in_ready", 32'(in_ready), 32'(!m_busy && !m_abort));
        check_val("nzcv", 32'(nzcv), 32'(m_nzcv));
        check_val("rf_we", 32'(rf_we), 32'(m_rf_we));
        check_val("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
        check_val("rf_wdata", rf_wdata, m_wdata);
        check_val("mem_req", 32'(mem_req), 32'(m_req));
        check_val("mem_we", 32'(mem_we), 32'(m_we));
        check_val("mem_addr", 32'(mem_addr), 32'(m_addr));
        check_val("mem_wdata", mem_wdata, m_mwdata);
        check_val("mem_err", 32'(mem_err), 32'(m_err));
        check_val("retire", 32'(retire), 32'(m_retire));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic issue(input logic [3:0] op, input logic s, input logic [31:0] res,
                         input logic [3:0] fl, input logic [3:0] dst,
                         input logic [15:0] addr, input logic [31:0] sd);
        in_valid = 1'b1; in_opcode = op; in_s = s; in_result = res; in_nzcv = fl;
        in_dst = dst; in_addr = addr; in_stdata = sd;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_opcode = OP_NOP; in_s = 1'b0; in_result = '0;
        in_nzcv = 4'b0000; in_dst = '0; in_addr = '0; in_stdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick();
        check_val("reset_nzcv", 32'(nzcv), 32'd0);
        check_val("reset_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick();

        // ADD with S set
        issue(OP_ADD, 1'b1, 32'h0000_0005, 4'b0000, 4'd3, 16'h0000, 32'h0);
        check_val("add_we", 32'(rf_we), 32'd1);
        check_val("add_waddr", 32'(rf_waddr), 32'd3);
        check_val("add_wdata", rf_wdata, 32'd5);
        check_val("add_retire", 32'(retire), 32'd1);

        // CMP sets flags, then ADD without S leaves them
        issue(OP_CMP, 1'b0, 32'h0, 4'b0110, 4'd1, 16'h0, 32'h0);
        check_val("cmp_nzcv", 32'(nzcv), 32'h6);
        check_val("cmp_no_we", 32'(rf_we), 32'd0);
        issue(OP_ADD, 1'b0, 32'h9, 4'b1000, 4'd2, 16'h0, 32'h0);
        check_val("add_s0_nzcv", 32'(nzcv), 32'h6);

        // LDR with ack on the third request cycle
        issue(OP_LDR, 1'b1, 32'h0, 4'b1111, 4'd7, 16'h0040, 32'h0);
        check_val("ldr_req1", 32'(mem_req), 32'd1);
        tick();
        tick();
        check_val("ldr_req3", 32'(mem_req), 32'd1);
        check_val("ldr_ready3", 32'(in_ready), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        check_val("ldr_wdata", rf_wdata, 32'hDEAD_BEEF);
        check_val("ldr_waddr", 32'(rf_waddr), 32'd7);
        check_val("ldr_req_drop", 32'(mem_req), 32'd0);
        check_val("ldr_nzcv", 32'(nzcv), 32'h6);

        // STR with immediate ack
        issue(OP_STR, 1'b0, 32'h0, 4'b0000, 4'd5, 16'h0010, 32'h1234_5678);
        check_val("str_we", 32'(mem_we), 32'd1);
        check_val("str_wdata", mem_wdata, 32'h1234_5678);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_val("str_no_rfwe", 32'(rf_we), 32'd0);
        check_val("str_retire", 32'(retire), 32'd1);

        // LDR timeout
        issue(OP_LDR, 1'b0, 32'h0, 4'b0000, 4'd9, 16'h0123, 32'h0);
        for (int i = 0; i < TO; i++) tick();
        check_val("to_err", 32'(mem_err), 32'd1);
        check_val("to_req", 32'(mem_req), 32'd0);
        tick();
        check_val("to_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a transaction, then a late ack
        issue(OP_LDR, 1'b0, 32'h0, 4'b0000, 4'd4, 16'h0200, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rst_req", 32'(mem_req), 32'd0);
        check_val("rst_ready", 32'(in_ready), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        check_val("late_ack_retire", 32'(retire), 32'd0);
        check_val("late_ack_we", 32'(rf_we), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            in_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 3) in_opcode = 4'(13 + $urandom_range(0, 1));
            else in_opcode = 4'($urandom_range(0, 15));
            in_s      = 1'($urandom_range(0, 1));
            in_result = $urandom;
            in_nzcv   = 4'($urandom_range(0, 15));
            in_dst    = 4'($urandom_range(0, 15));
            in_addr   = 16'($urandom);
            in_stdata = $urandom;
            mem_ack   = ($urandom_range(0, 9) < 3);
            mem_rdata = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
